// File: rtl/result_writeback_if.sv
// result_writeback_if: bundle connecting the systolic-array result side, the
// result SRAM write port and the writeback status flags.
//   start_check, BankAddr, tile_in : finished tile from the array
//   wr_ready                       : SRAM accepts a write this cycle
//   wr_en, wr_addr, wr_data        : SRAM write request, {tile index, beat}, 256b beat
//   fifo_level, overflow, done     : buffer occupancy and sticky status flags
//   checksum                       : running XOR of accepted beats (WB_CHECKSUM_EN only)
// master: the writeback block. slave: its environment.
interface result_writeback_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned TILE_W  = 16 * DATA_WIDTH;
  localparam int unsigned BEAT_W  = 8 * DATA_WIDTH;
  localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic                  start_check;
  logic [ADDR_WIDTH-1:0] BankAddr;
  logic [TILE_W-1:0]     tile_in;
  logic                  wr_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   wr_addr;
  logic [BEAT_W-1:0]     wr_data;
  logic [LEVEL_W-1:0]    fifo_level;
  logic                  overflow;
  logic                  done;
`ifdef WB_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;
`endif

  modport master (
    input  start_check, BankAddr, tile_in, wr_ready,
    output wr_en, wr_addr, wr_data, fifo_level, overflow, done
`ifdef WB_CHECKSUM_EN
    , checksum
`endif
  );

  modport slave (
    output start_check, BankAddr, tile_in, wr_ready,
    input  wr_en, wr_addr, wr_data, fifo_level, overflow, done
`ifdef WB_CHECKSUM_EN
    , checksum
`endif
  );
endinterface

// File: rtl/result_writeback.sv
// result_writeback: captures finished 4x4 result tiles (16 x 32b) from the
// systolic array, buffers them in a small FIFO and drains each tile as two
// 256b beats into the result SRAM, honouring wr_ready back-pressure.
// Ports:
//   clk     : system clock, rising edge
//   rstSys  : synchronous reset, active-high
//   bus     : result_writeback_if.master (capture inputs, SRAM write port, status)
// Optional feature: define WB_CHECKSUM_EN to add bus.checksum, the running XOR
// of all 32b words of every accepted beat.
module result_writeback #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned NUM_CASES  = 1024,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rstSys,
  result_writeback_if.master bus
);
  localparam int unsigned WORDS_PER_BEAT = 8;
  localparam int unsigned TILE_W  = 16 * DATA_WIDTH;
  localparam int unsigned BEAT_W  = WORDS_PER_BEAT * DATA_WIDTH;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LEVEL_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_CASES - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] idx;
    logic [TILE_W-1:0]     tile;
  } fifoEntry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } drainState_t;

  drainState_t           state, stateNext;
  fifoEntry_t            fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rdPtr, wrPtr;
  logic [LEVEL_W-1:0]    count;
  logic                  firstSeen;
  logic [ADDR_WIDTH-1:0] lastAddr;
  logic                  wrEn, wrEnNext;
  logic [ADDR_WIDTH:0]   wrAddr, wrAddrNext;
  logic [BEAT_W-1:0]     wrData, wrDataNext;
  logic                  overflowR, doneR;

  logic                  capture, push, pop, full, beatAccept;
  fifoEntry_t            pushEntry, headEntry, nextHead;

  // Capture only on a new index, or the first valid result since reset.
  assign capture    = bus.start_check && (!firstSeen || (bus.BankAddr != lastAddr));
  assign beatAccept = wrEn && bus.wr_ready;
  assign pop        = beatAccept && (state == BEAT1);
  assign full       = (count == LEVEL_W'(FIFO_DEPTH));
  // A pop on the same edge frees the slot a full FIFO would otherwise refuse.
  assign push       = capture && (!full || pop);
  assign pushEntry  = {bus.BankAddr, bus.tile_in};
  assign headEntry  = fifoMem[rdPtr];
  // Head after a pop: the next stored entry, or the tile being pushed right now.
  assign nextHead   = (count > LEVEL_W'(1)) ? fifoMem[rdPtr + PTR_W'(1)] : pushEntry;

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (rstSys) state <= IDLE;
    else        state <= stateNext;
  end

  // Drain FSM next state and next registered write-port values.
  always_comb begin
    stateNext  = state;
    wrEnNext   = wrEn;
    wrAddrNext = wrAddr;
    wrDataNext = wrData;
    case (state)
      IDLE: begin
        if (count != LEVEL_W'(0)) begin
          stateNext  = BEAT0;
          wrEnNext   = 1'b1;
          wrAddrNext = {headEntry.idx, 1'b0};
          wrDataNext = headEntry.tile[TILE_W-1:BEAT_W];
        end
      end
      BEAT0: begin
        if (bus.wr_ready) begin
          stateNext  = BEAT1;
          wrAddrNext = {headEntry.idx, 1'b1};
          wrDataNext = headEntry.tile[BEAT_W-1:0];
        end
      end
      BEAT1: begin
        if (bus.wr_ready) begin
          if ((count > LEVEL_W'(1)) || push) begin
            stateNext  = BEAT0;
            wrAddrNext = {nextHead.idx, 1'b0};
            wrDataNext = nextHead.tile[TILE_W-1:BEAT_W];
          end else begin
            stateNext = IDLE;
            wrEnNext  = 1'b0;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        wrEnNext  = 1'b0;
      end
    endcase
  end

  // Write port registers, FIFO bookkeeping and sticky flags.
  always_ff @(posedge clk) begin
    if (rstSys) begin
      wrEn      <= 1'b0;
      wrAddr    <= '0;
      wrData    <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      firstSeen <= 1'b0;
      lastAddr  <= '0;
      overflowR <= 1'b0;
      doneR     <= 1'b0;
    end else begin
      wrEn   <= wrEnNext;
      wrAddr <= wrAddrNext;
      wrData <= wrDataNext;
      if (capture) begin
        firstSeen <= 1'b1;
        lastAddr  <= bus.BankAddr;
      end
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      if (push && !pop)      count <= count + LEVEL_W'(1);
      else if (pop && !push) count <= count - LEVEL_W'(1);
      if (capture && !push) overflowR <= 1'b1;
      if (pop && (headEntry.idx == LAST_IDX)) doneR <= 1'b1;
    end
  end

  // Tile storage; contents need no reset since the pointers gate all reads.
  always_ff @(posedge clk) begin
    if (push && !rstSys) fifoMem[wrPtr] <= pushEntry;
  end

  assign bus.wr_en      = wrEn;
  assign bus.wr_addr    = wrAddr;
  assign bus.wr_data    = wrData;
  assign bus.fifo_level = count;
  assign bus.overflow   = overflowR;
  assign bus.done       = doneR;

`ifdef WB_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksumR;

  function automatic logic [DATA_WIDTH-1:0] beatXor(input logic [BEAT_W-1:0] beat);
    logic [DATA_WIDTH-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < WORDS_PER_BEAT; i++) begin
      acc = acc ^ beat[i*DATA_WIDTH +: DATA_WIDTH];
    end
    return acc;
  endfunction

  // Running XOR over every beat the SRAM accepts.
  always_ff @(posedge clk) begin
    if (rstSys)          checksumR <= '0;
    else if (beatAccept) checksumR <= checksumR ^ beatXor(wrData);
  end

  assign bus.checksum = checksumR;
`endif
endmodule

// File: tb/tb_result_writeback.sv
// tb_result_writeback: directed self-checking bench for result_writeback.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. A falling-edge monitor logs every write that will be accepted.
module tb_result_writeback;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned NUM_CASES  = 1024;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned TILE_W     = 512;
  localparam int unsigned BEAT_W     = 256;

  logic clk;
  logic rstSys;
  int   checks;
  int   errors;

  result_writeback_if #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) bus ();

  result_writeback #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_CASES(NUM_CASES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rstSys(rstSys),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Accepted-write log, cleared while reset is held.
  logic [10:0]  obsAddr [$];
  logic [255:0] obsData [$];
  int           obsCyc  [$];
  int           cyc;
  logic         doneSeen;
  int           doneCyc;

  initial begin
    cyc      = 0;
    doneSeen = 1'b0;
    doneCyc  = 0;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rstSys) begin
      obsAddr.delete();
      obsData.delete();
      obsCyc.delete();
      doneSeen <= 1'b0;
    end else begin
      if (bus.wr_en && bus.wr_ready) begin
        obsAddr.push_back(bus.wr_addr);
        obsData.push_back(bus.wr_data);
        obsCyc.push_back(cyc);
      end
      if (bus.done && !doneSeen) begin
        doneSeen <= 1'b1;
        doneCyc  <= cyc;
      end
    end
  end

  function automatic logic [TILE_W-1:0] tileData(input int idx);
    logic [TILE_W-1:0] t;
    t = '0;
    for (int w = 0; w < 16; w++) t[TILE_W-1-32*w -: 32] = {8'(w), 8'hC3, 16'(idx)};
    return t;
  endfunction

  function automatic logic [BEAT_W-1:0] beatData(input int idx, input int beat);
    logic [TILE_W-1:0] t;
    t = tileData(idx);
    return (beat == 0) ? t[511:256] : t[255:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstSys          = 1'b1;
    bus.start_check = 1'b0;
    bus.wr_ready    = 1'b0;
    repeat (2) step();
    rstSys = 1'b0;
  endtask

  task automatic send_tile(input int idx, input logic [TILE_W-1:0] t);
    bus.start_check = 1'b1;
    bus.BankAddr    = 10'(idx);
    bus.tile_in     = t;
    step();
    bus.start_check = 1'b0;
  endtask

  task automatic test_reset();
    logic sawEn;
    sample();
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL por_wr_en: got %0b, required 0", bus.wr_en); end
    checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL por_level: got %0d, required 0", bus.fifo_level); end
    step();
    // Fill past capacity, start draining, then reset mid-drain.
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_tile(i, tileData(i));
    bus.wr_ready = 1'b1;
    step();
    rstSys = 1'b1;
    step();
    sample();
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %0b, required 0", bus.wr_en); end
    checks++; if (bus.wr_addr !== 11'd0) begin errors++; $display("FAIL rst_wr_addr: got %0h, required 0", bus.wr_addr); end
    checks++; if (bus.wr_data !== 256'd0) begin errors++; $display("FAIL rst_wr_data: got %0h, required 0", bus.wr_data); end
    checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d, required 0", bus.fifo_level); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %0b, required 0", bus.overflow); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b, required 0", bus.done); end
    step();
    rstSys = 1'b0;
    sawEn  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      sawEn = sawEn | bus.wr_en;
      step();
    end
    checks++; if (sawEn !== 1'b0) begin errors++; $display("FAIL rst_no_writes: wr_en seen %0b, required 0", sawEn); end
    checks++; if (obsAddr.size() != 0) begin errors++; $display("FAIL rst_no_accepts: got %0d, required 0", obsAddr.size()); end
  endtask

  task automatic test_single_tile();
    do_reset();
    bus.wr_ready = 1'b1;
    send_tile(5, tileData(5));
    sample();
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL t2_idle_cycle: wr_en got %0b, required 0", bus.wr_en); end
    checks++; if (bus.fifo_level !== 3'd1) begin errors++; $display("FAIL t2_level: got %0d, required 1", bus.fifo_level); end
    step();
    sample();
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 11'd10) begin errors++; $display("FAIL t2_beat0_addr: en %0b addr %0d, required 1 10", bus.wr_en, bus.wr_addr); end
    checks++; if (bus.wr_data !== beatData(5, 0)) begin errors++; $display("FAIL t2_beat0_data: got %0h, required %0h", bus.wr_data, beatData(5, 0)); end
    step();
    sample();
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 11'd11) begin errors++; $display("FAIL t2_beat1_addr: en %0b addr %0d, required 1 11", bus.wr_en, bus.wr_addr); end
    checks++; if (bus.wr_data !== beatData(5, 1)) begin errors++; $display("FAIL t2_beat1_data: got %0h, required %0h", bus.wr_data, beatData(5, 1)); end
    step();
    sample();
    checks++; if (bus.wr_en !== 1'b0 || bus.fifo_level !== 3'd0) begin errors++; $display("FAIL t2_after: en %0b level %0d, required 0 0", bus.wr_en, bus.fifo_level); end
    step();
  endtask

  task automatic test_hold_dedup();
    do_reset();
    bus.wr_ready    = 1'b1;
    bus.start_check = 1'b1;
    bus.BankAddr    = 10'd3;
    bus.tile_in     = tileData(3);
    repeat (17) step();
    bus.start_check = 1'b0;
    repeat (6) step();
    checks++; if (obsAddr.size() != 2) begin errors++; $display("FAIL t3_write_count: got %0d, required 2", obsAddr.size()); end
    else begin
      checks++; if (obsAddr[0] !== 11'd6 || obsAddr[1] !== 11'd7) begin errors++; $display("FAIL t3_addrs: got %0d %0d, required 6 7", obsAddr[0], obsAddr[1]); end
    end
  endtask

  task automatic test_overflow();
    int bad;
    do_reset();
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_tile(i, tileData(i));
    sample();
    checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL t4_level: got %0d, required 4", bus.fifo_level); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL t4_overflow: got %0b, required 1", bus.overflow); end
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 11'd0 || bus.wr_data !== beatData(0, 0)) begin errors++; $display("FAIL t4_stall_a: en %0b addr %0d data %0h, required 1 0 %0h", bus.wr_en, bus.wr_addr, bus.wr_data, beatData(0, 0)); end
    repeat (3) step();
    sample();
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 11'd0 || bus.wr_data !== beatData(0, 0)) begin errors++; $display("FAIL t4_stall_b: en %0b addr %0d data %0h, required 1 0 %0h", bus.wr_en, bus.wr_addr, bus.wr_data, beatData(0, 0)); end
    step();
    bus.wr_ready = 1'b1;
    repeat (12) step();
    checks++; if (obsAddr.size() != 8) begin errors++; $display("FAIL t4_write_count: got %0d, required 8", obsAddr.size()); end
    else begin
      bad = 0;
      for (int k = 0; k < 8; k++) begin
        if (obsAddr[k] !== 11'(k) || obsData[k] !== beatData(k / 2, k % 2) || obsCyc[k] != obsCyc[0] + k) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL t4_sequence: %0d bad writes, required 0", bad); end
    end
    sample();
    checks++; if (bus.fifo_level !== 3'd0 || bus.overflow !== 1'b1) begin errors++; $display("FAIL t4_end: level %0d overflow %0b, required 0 1", bus.fifo_level, bus.overflow); end
    step();
  endtask

  task automatic test_back_to_back();
    logic found;
    int   bad;
    do_reset();
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_tile(i, tileData(i));
    bus.wr_ready = 1'b1;
    found = 1'b0;
    // Push tile 4 on exactly the edge that pops tile 0 from a full FIFO.
    for (int c = 0; c < 8 && !found; c++) begin
      if (bus.wr_en && bus.wr_addr == 11'd1) begin
        found = 1'b1;
        send_tile(4, tileData(4));
      end else begin
        step();
      end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL bb_find_beat1: got %0b, required 1", found); end
    repeat (12) step();
    sample();
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL bb_overflow: got %0b, required 0", bus.overflow); end
    checks++; if (obsAddr.size() != 10) begin errors++; $display("FAIL bb_write_count: got %0d, required 10", obsAddr.size()); end
    else begin
      bad = 0;
      for (int k = 0; k < 10; k++) begin
        if (obsAddr[k] !== 11'(k) || obsData[k] !== beatData(k / 2, k % 2) || obsCyc[k] != obsCyc[0] + k) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL bb_sequence: %0d bad writes, required 0", bad); end
    end
    step();
  endtask

  task automatic test_done();
    int sent;
    int bad;
    do_reset();
    sent = 0;
    for (int c = 0; c < 20000 && obsAddr.size() < 2 * NUM_CASES; c++) begin
      bus.wr_ready = ($urandom_range(0, 3) != 0);
      if (sent < NUM_CASES && bus.fifo_level < 3'(FIFO_DEPTH)) begin
        bus.start_check = 1'b1;
        bus.BankAddr    = 10'(sent);
        bus.tile_in     = tileData(sent);
        sent++;
      end else begin
        bus.start_check = 1'b0;
      end
      step();
    end
    bus.start_check = 1'b0;
    bus.wr_ready    = 1'b1;
    repeat (4) step();
    checks++; if (obsAddr.size() != 2 * NUM_CASES) begin errors++; $display("FAIL t5_write_count: got %0d, required %0d", obsAddr.size(), 2 * NUM_CASES); end
    else begin
      bad = 0;
      for (int k = 0; k < 2 * NUM_CASES; k++) begin
        if (obsAddr[k] !== 11'(k) || obsData[k] !== beatData(k / 2, k % 2)) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL t5_stream: %0d bad writes, required 0", bad); end
      checks++; if (obsAddr[2*NUM_CASES-1] !== 11'd2047) begin errors++; $display("FAIL t5_last_addr: got %0d, required 2047", obsAddr[2*NUM_CASES-1]); end
      checks++; if (!doneSeen || doneCyc != obsCyc[2*NUM_CASES-1] + 1) begin errors++; $display("FAIL t5_done_timing: seen %0b cycle %0d, required 1 %0d", doneSeen, doneCyc, obsCyc[2*NUM_CASES-1] + 1); end
    end
    sample();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL t5_done: got %0b, required 1", bus.done); end
    checks++; if (bus.overflow !== 1'b0 || bus.fifo_level !== 3'd0) begin errors++; $display("FAIL t5_end: overflow %0b level %0d, required 0 0", bus.overflow, bus.fifo_level); end
    step();
  endtask

`ifdef WB_CHECKSUM_EN
  task automatic test_checksum();
    logic [TILE_W-1:0] t;
    do_reset();
    sample();
    checks++; if (bus.checksum !== 32'h0) begin errors++; $display("FAIL t6_reset: got %0h, required 0", bus.checksum); end
    step();
    bus.wr_ready = 1'b1;
    t = '0;
    for (int w = 0; w < 16; w++) t[TILE_W-1-32*w -: 32] = 32'h1;
    send_tile(0, t);
    repeat (5) step();
    checks++; if (bus.checksum !== 32'h0) begin errors++; $display("FAIL t6_ones: got %0h, required 0", bus.checksum); end
    t = '0;
    t[511:480] = 32'hA5;
    send_tile(1, t);
    repeat (5) step();
    checks++; if (bus.checksum !== 32'hA5) begin errors++; $display("FAIL t6_a5: got %0h, required a5", bus.checksum); end
  endtask
`endif

  initial begin
    checks          = 0;
    errors          = 0;
    rstSys          = 1'b1;
    bus.start_check = 1'b0;
    bus.BankAddr    = '0;
    bus.tile_in     = '0;
    bus.wr_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstSys = 1'b0;
    test_reset();
    test_single_tile();
    test_hold_dedup();
    test_overflow();
    test_back_to_back();
    test_done();
`ifdef WB_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
